yscaler_line_sched: RTL
=======================

// Module: yscaler_line_sched
// PURPOSE
//  Per-frame line scheduler for the vertical bilinear scaler core. Sequences one frame:
//  - resets the core and fetches input lines from the line-buffer writer;
//  - starts output lines on the line-buffer reader;
//  - pulses the core's update_mul to advance the scaling ratio.
//  Sits between the frame-sync/config logic and the core plus its line-buffer ports.
// PARAMETERS
//  C_RESO_WIDTH  10  width of line counts and sizes (matches core)
// PORTS
//  clk            in   1   clock
//  resetn         in   1   reset, synchronous, active-low
//  start          in   1   frame start pulse; ignored unless IDLE
//  abort          in   1   frame abort; returns to IDLE next cycle
//  ori_size       in   RW  input line count, sampled on accepted start
//  scale_size     in   RW  output line count, sampled on accepted start
//  sc_resetn      out  1   core reset, active-low
//  sc_update_mul  out  1   core advance pulse
//  sc_repeat_line in   1   core: next output reuses current input pair
//  sc_ovalid      in   1   core: current output line computable
//  sc_m_inv_cnt   in   RW  core: remaining-input counter (1 = last line held)
//  in_req         out  1   request next input line
//  in_ack         in   1   input line stored; transfer when in_req&in_ack
//  out_start      out  1   one-cycle pulse: emit current output line
//  out_done       in   1   output line fully sent
//  busy           out  1   high in every state except IDLE
//  frame_done     out  1   one-cycle pulse at normal frame end
//  err            out  1   sticky: fetch needed with no input left; cleared on accepted start
// BEHAVIOUR
//  Reset: all outputs 0 except sc_resetn=0 (core held in reset while IDLE).
//  States and transitions:
//  - IDLE: accepted start latches sizes, in_rem=ori_size, out_rem=scale_size, err=0; next INIT.
//  - INIT: sc_resetn=0 for exactly 1 cycle; next FETCH.
//  - FETCH: in_req=1 held until in_ack; on transfer in_rem-=1, in_req drops the same edge; next SETTLE.
//  - SETTLE: 1 cycle, lets core registers/compares settle; next CHECK.
//  - CHECK:
//    - if sc_ovalid: out_start pulse; next EMIT.
//    - else: next STEP.
//  - EMIT: wait out_done; out_rem-=1; if out_rem==0 -> frame_done pulse, IDLE; else STEP.
//  - STEP: sc_update_mul=1 for 1 cycle.
//    - need_fetch = ~sc_repeat_line & (sc_m_inv_cnt!=1), sampled this cycle.
//    - if need_fetch & in_rem==0: set err, go IDLE (no frame_done).
//    - else next STEP2.
//  - STEP2: 1 cycle settle; need_fetch -> FETCH, else CHECK.
//  Outside INIT, sc_resetn=1 in all non-IDLE states.
//  Single-cycle pulses:
//  - sc_update_mul: only in STEP.
//  - out_start: only CHECK->EMIT.
//  - frame_done: only EMIT->IDLE.
//  Bottom-edge extension: once in_rem==0 and sc_m_inv_cnt==1, STEPs never fetch (last line repeated).
//  abort: highest priority after resetn, any state; next IDLE, in_req=0, no frame_done, err unchanged.
//  start while busy: ignored, no effect on latched sizes.
//  out_done outside EMIT, in_ack without in_req: ignored.
//  Sizes of 0 at start: err=1, stay IDLE.
//  Counters are RW bits, never wrap: decrement only when >0.
// TESTING
//  - ori=4, scale=8, in_ack/out_done 2 cycles after request -> 4 in transfers, 8 out_start, 1 frame_done, err=0.
//  - ori=8, scale=4 -> 8 in transfers, 4 out_start, sc_update_mul count == transfers-1 + skipped outputs; frame_done once.
//  - ori=1, scale=3 -> exactly 1 in transfer, 3 out_start, no further in_req.
//  - ori=4, scale=8, in_ack delayed 20 cycles on 2nd line -> in_req held high all 20 cycles, no out_start meanwhile.
//  - abort during EMIT of 3rd line -> IDLE next cycle, busy=0, sc_resetn=0, no frame_done; next start runs a full frame.
//  - resetn low mid-FETCH, and start while busy -> all outputs at reset values; sizes unchanged by busy start.

Source files
------------

// File: rtl/yscaler_line_sched.sv
// Per-frame line scheduler for the vertical bilinear scaler core: resets the core,
// fetches input lines, launches output lines and advances the scaling ratio.
module yscaler_line_sched #(
    parameter int C_RESO_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [C_RESO_WIDTH-1:0] ori_size,
    input  logic [C_RESO_WIDTH-1:0] scale_size,
    output logic                    sc_resetn,
    output logic                    sc_update_mul,
    input  logic                    sc_repeat_line,
    input  logic                    sc_ovalid,
    input  logic [C_RESO_WIDTH-1:0] sc_m_inv_cnt,
    output logic                    in_req,
    input  logic                    in_ack,
    output logic                    out_start,
    input  logic                    out_done,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err
);

    localparam logic [C_RESO_WIDTH-1:0] CNT_ZERO = {C_RESO_WIDTH{1'b0}};
    localparam logic [C_RESO_WIDTH-1:0] CNT_ONE  = {{(C_RESO_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_FETCH  = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_EMIT   = 3'd5,
        S_STEP   = 3'd6,
        S_STEP2  = 3'd7
    } state_t;

    state_t                  state_q;
    logic [C_RESO_WIDTH-1:0] in_rem_q;
    logic [C_RESO_WIDTH-1:0] out_rem_q;
    logic                    need_fetch_q;
    logic                    sc_resetn_q;
    logic                    sc_update_mul_q;
    logic                    in_req_q;
    logic                    out_start_q;
    logic                    busy_q;
    logic                    frame_done_q;
    logic                    err_q;

    logic                    need_fetch_s;
    logic [C_RESO_WIDTH-1:0] in_rem_dec_s;
    logic [C_RESO_WIDTH-1:0] out_rem_dec_s;

    // Saturating decrement: line counters stop at zero instead of wrapping.
    function automatic logic [C_RESO_WIDTH-1:0] sat_dec(input logic [C_RESO_WIDTH-1:0] v);
        if (v != CNT_ZERO) begin
            sat_dec = v - CNT_ONE;
        end else begin
            sat_dec = CNT_ZERO;
        end
    endfunction

    // m_inv_cnt==1 means the last input line is already held, so the bottom edge repeats it.
    assign need_fetch_s  = ~sc_repeat_line & (sc_m_inv_cnt != CNT_ONE);
    assign in_rem_dec_s  = sat_dec(in_rem_q);
    assign out_rem_dec_s = sat_dec(out_rem_q);

    // Frame sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            in_rem_q        <= CNT_ZERO;
            out_rem_q       <= CNT_ZERO;
            need_fetch_q    <= 1'b0;
            sc_resetn_q     <= 1'b0;
            sc_update_mul_q <= 1'b0;
            in_req_q        <= 1'b0;
            out_start_q     <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            err_q           <= 1'b0;
        end else if (abort) begin
            state_q         <= S_IDLE;
            sc_resetn_q     <= 1'b0;
            sc_update_mul_q <= 1'b0;
            in_req_q        <= 1'b0;
            out_start_q     <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            sc_update_mul_q <= 1'b0;
            out_start_q     <= 1'b0;
            frame_done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if ((ori_size == CNT_ZERO) || (scale_size == CNT_ZERO)) begin
                            err_q <= 1'b1;
                        end else begin
                            in_rem_q  <= ori_size;
                            out_rem_q <= scale_size;
                            err_q     <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    sc_resetn_q <= 1'b1;
                    in_req_q    <= 1'b1;
                    state_q     <= S_FETCH;
                end
                S_FETCH: begin
                    if (in_ack) begin
                        in_req_q <= 1'b0;
                        in_rem_q <= in_rem_dec_s;
                        state_q  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (sc_ovalid) begin
                        out_start_q <= 1'b1;
                        state_q     <= S_EMIT;
                    end else begin
                        sc_update_mul_q <= 1'b1;
                        state_q         <= S_STEP;
                    end
                end
                S_EMIT: begin
                    if (out_done) begin
                        out_rem_q <= out_rem_dec_s;
                        if (out_rem_dec_s == CNT_ZERO) begin
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            sc_resetn_q  <= 1'b0;
                            state_q      <= S_IDLE;
                        end else begin
                            sc_update_mul_q <= 1'b1;
                            state_q         <= S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    need_fetch_q <= need_fetch_s;
                    if (need_fetch_s && (in_rem_q == CNT_ZERO)) begin
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        sc_resetn_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q <= S_STEP2;
                    end
                end
                S_STEP2: begin
                    if (need_fetch_q) begin
                        in_req_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end else begin
                        state_q <= S_CHECK;
                    end
                end
                default: begin
                    in_req_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    sc_resetn_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign sc_resetn     = sc_resetn_q;
    assign sc_update_mul = sc_update_mul_q;
    assign in_req        = in_req_q;
    assign out_start     = out_start_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign err           = err_q;

endmodule
